onehot_pulse_decoder: RTL

Sequential 3-to-8 decoder, the receiving end of the 8-to-3 priority encoder interface. It accepts one encoded index (Y2..Y0 plus the Idle flag) per valid/ready handshake and drives the matching one-hot line high for a programmable number of clock cycles. After each pulse it inserts a one-cycle gap, so downstream logic always sees clean, separated pulses. It sits between the encoder's registered output and the per-line consumers (interrupt acknowledge, channel strobes).

---
 rtl/onehot_pulse_decoder_pkg.sv | 28 ++
 rtl/onehot_pulse_decoder_reencode.sv | 33 +++
 rtl/onehot_pulse_decoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/onehot_pulse_decoder_pkg.sv
// ----------------------------------------------------------------------------
// onehot_pulse_decoder_pkg
// Shared definitions for the one-hot pulse decoder:
//   - state_t        : decoder FSM states (S_IDLE, S_HOLD, S_GAP)
//   - ONEHOT_W/CODE_W: one-hot line count and encoded index width (8/3)
//   - CNT_W_DEF      : default hold-counter / pulse_count width
//   - pcount_sat()   : saturation value of a pulse_count of a given width
// ----------------------------------------------------------------------------
package onehot_pulse_decoder_pkg;

    localparam int ONEHOT_W  = 8;
    localparam int CODE_W    = 3;
    localparam int POP_W     = 4;   // popcount of 8 bits needs 0..8
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // All-ones value for a counter of width w (w clamped to 32 bits).
    function automatic logic [31:0] pcount_sat(input int w);
        if (w >= 32) return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_reencode.sv
// ----------------------------------------------------------------------------
// onehot_reencode
// Combinational 8-to-3 priority re-encoder with popcount, used by the
// decoder's self-check. Highest set bit wins the index.
// Only compiled when PULSE_DECODER_CHECK_EN is defined, since it has no
// user in the default build.
// Ports:
//   i_vec [7:0]  vector to re-encode
//   o_idx [2:0]  index of the highest set bit (0 when i_vec == 0)
//   o_pop [3:0]  number of set bits in i_vec
// ----------------------------------------------------------------------------
`ifdef PULSE_DECODER_CHECK_EN
module onehot_reencode
    import onehot_pulse_decoder_pkg::*;
(
    input  logic [ONEHOT_W-1:0] i_vec,
    output logic [CODE_W-1:0]   o_idx,
    output logic [POP_W-1:0]    o_pop
);

    always_comb begin
        o_idx = '0;
        o_pop = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (i_vec[i]) begin
                o_idx = CODE_W'(i);
                o_pop = o_pop + POP_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/onehot_pulse_decoder.sv
// ----------------------------------------------------------------------------
// onehot_pulse_decoder
// Sequential 3-to-8 decoder. Accepts one encoded index per valid/ready
// handshake and drives the matching one-hot line for HOLD_CYCLES cycles,
// followed by a one-cycle gap before the next transfer can be accepted.
// Optional self-check: define PULSE_DECODER_CHECK_EN to build the re-encoder
// checker driving err; otherwise err is tied to 0.
// Parameters:
//   HOLD_CYCLES  pulse length in cycles (1..255)
//   CNT_W        width of hold counter and pulse_count
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     in_code/in_idle valid
//   in_ready     accept strobe, high only in S_IDLE out of reset
//   in_code[2:0] encoded index (Y2..Y0)
//   in_idle      encoder idle flag; transfer is consumed but ignored
//   out_onehot   one-hot pulse output
//   out_active   high while out_onehot != 0
//   pulse_count  saturating count of pulses issued
//   err          sticky self-check error
// ----------------------------------------------------------------------------
module onehot_pulse_decoder
    import onehot_pulse_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_idle,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic                out_active,
    output logic [CNT_W-1:0]    pulse_count,
    output logic                err
);

    localparam logic [CNT_W-1:0] W_SAT  = CNT_W'(pcount_sat(CNT_W));
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ONEHOT_W-1:0]   r_onehot;
    logic                  r_active;
    logic [CNT_W-1:0]      r_pcount;

    // in_ready is the only combinational output; gating with rst_n keeps it
    // low for the whole reset assertion.
    assign in_ready    = rst_n && (r_state == S_IDLE);
    assign out_onehot  = r_onehot;
    assign out_active  = r_active;
    assign pulse_count = r_pcount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_active <= 1'b0;
            r_pcount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Idle-flagged transfers are consumed with no effect.
                    if (in_valid && !in_idle) begin
                        r_onehot <= ONEHOT_W'(1) << in_code;
                        r_active <= 1'b1;
                        r_cnt    <= W_LOAD;
                        if (r_pcount != W_SAT)
                            r_pcount <= r_pcount + CNT_W'(1);
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Loaded with HOLD_CYCLES-1 so the line is high for
                    // exactly HOLD_CYCLES cycles including the load cycle.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_onehot <= '0;
                        r_active <= 1'b0;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PULSE_DECODER_CHECK_EN
    logic [CODE_W-1:0] r_code;
    logic              r_err;
    logic [CODE_W-1:0] w_idx;
    logic [POP_W-1:0]  w_pop;

    onehot_reencode u_reencode (
        .i_vec (r_onehot),
        .o_idx (w_idx),
        .o_pop (w_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid && !in_idle)
                r_code <= in_code;
            // Sticky: once a bad pulse is seen only reset clears it.
            if (r_active && ((w_pop != POP_W'(1)) || (w_idx != r_code)))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
